// File: rtl/pcpi_div_pkg.sv
// Shared constants and types for the parametrised PCPI divider.
// Provides the RV32M opcode/funct constants, the FSM state enum, the
// latched-operation control struct and the instruction decode helper.
package pcpi_div_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } div_state_t;

  // Per-operation control latched at acceptance.
  typedef struct packed {
    logic is_rem;   // return remainder instead of quotient
    logic neg_quo;  // negate quotient at completion
    logic neg_rem;  // negate remainder at completion
  } op_ctl_t;

  // True for DIV/DIVU/REM/REMU encodings.
  function automatic logic is_div_insn(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV) && insn[14];
  endfunction

endpackage

// File: rtl/pcpi_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem      - partial remainder accumulator (XLEN+1 bits, top bit always 0)
//   quo      - dividend/quotient shift register; MSB is the next dividend bit
//   divisor  - divisor magnitude
//   rem_next - remainder after shift and conditional subtract
//   quo_next - shift register with the new quotient bit shifted in at bit 0
module pcpi_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          unused_rem_top;

  // Remainder is always below the divisor, so its top bit never carries data.
  assign unused_rem_top = rem[XLEN];

  assign shifted  = {rem[XLEN-1:0], quo[XLEN-1]};
  assign trial    = shifted - {1'b0, divisor};

  // A set sign bit on the trial means the subtract underflowed: restore.
  assign rem_next = trial[XLEN] ? shifted : trial;
  assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/pcpi_div_param.sv
// Parametrised PCPI divider for RV M-extension DIV/DIVU/REM/REMU.
// Retires RADIX_LOG2 quotient bits per clock using a chain of restoring
// steps; divide-by-zero and signed overflow complete in one edge; the
// operation is abandoned if pcpi_valid drops while calculating.
// Optional macro PCPI_DIV_REUSE_EN: remember the last completed operands
// and results so a repeated rs1/rs2/signedness pair completes in one edge.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   pcpi_valid/insn      - instruction offered by the core
//   pcpi_rs1/rs2         - dividend / divisor
//   pcpi_wr/ready        - one-cycle completion and write-back strobe
//   pcpi_rd              - result, held until the next completion
//   pcpi_wait            - busy while an accepted op is in flight
module pcpi_div_param
  import pcpi_div_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int unsigned STEPS = XLEN / RADIX_LOG2;
  localparam int unsigned CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   rem_q, rem_d;
  op_ctl_t         ctl_q, ctl_d;
  logic            wait_q, wait_d;
  logic            ready_q, ready_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] rd_q, rd_d;

  logic            start_c, signed_c, s1_c, s2_c, div0_c, ovf_c, hit_c;
  logic [XLEN-1:0] mag1_c, mag2_c, q_fin_c, r_fin_c;
  logic            unused_insn;

  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Decode and operand preparation for the acceptance edge.
  assign start_c  = pcpi_valid && is_div_insn(pcpi_insn);
  assign signed_c = ~pcpi_insn[12];
  assign s1_c     = signed_c & pcpi_rs1[XLEN-1];
  assign s2_c     = signed_c & pcpi_rs2[XLEN-1];
  assign mag1_c   = s1_c ? ('0 - pcpi_rs1) : pcpi_rs1;
  assign mag2_c   = s2_c ? ('0 - pcpi_rs2) : pcpi_rs2;
  assign div0_c   = (pcpi_rs2 == '0);
  assign ovf_c    = signed_c && (pcpi_rs1 == MOST_NEG) && (pcpi_rs2 == '1);

  // Sign correction applied when the result is registered.
  assign q_fin_c = ctl_q.neg_quo ? ('0 - quo_q) : quo_q;
  assign r_fin_c = ctl_q.neg_rem ? ('0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];

  // Chain of restoring steps evaluated each CALC cycle.
  logic [XLEN:0]   rem_chain [RADIX_LOG2+1];
  logic [XLEN-1:0] quo_chain [RADIX_LOG2+1];

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar g = 0; g < int'(RADIX_LOG2); g++) begin : g_step
    pcpi_div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_chain[g]),
      .quo      (quo_chain[g]),
      .divisor  (dvs_q),
      .rem_next (rem_chain[g+1]),
      .quo_next (quo_chain[g+1])
    );
  end

`ifdef PCPI_DIV_REUSE_EN
  logic            last_valid_q, last_valid_d;
  logic            last_uns_q, last_uns_d;
  logic [XLEN-1:0] last_rs1_q, last_rs1_d;
  logic [XLEN-1:0] last_rs2_q, last_rs2_d;
  logic [XLEN-1:0] last_quo_q, last_quo_d;
  logic [XLEN-1:0] last_rem_q, last_rem_d;

  assign hit_c = last_valid_q && (pcpi_rs1 == last_rs1_q) && (pcpi_rs2 == last_rs2_q) &&
                 (pcpi_insn[12] == last_uns_q);
`else
  assign hit_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_c) state_d = (div0_c || ovf_c || hit_c) ? DONE : CALC;
      CALC: begin
        if (!pcpi_valid)            state_d = IDLE;
        else if (count_q == CW'(1)) state_d = DONE;
      end
      DONE: state_d = HOLD;
      HOLD: if (!pcpi_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    count_d = count_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    ctl_d   = ctl_q;
    wait_d  = wait_q;
    ready_d = 1'b0;
    wr_d    = 1'b0;
    rd_d    = rd_q;
`ifdef PCPI_DIV_REUSE_EN
    last_valid_d = last_valid_q;
    last_uns_d   = last_uns_q;
    last_rs1_d   = last_rs1_q;
    last_rs2_d   = last_rs2_q;
    last_quo_d   = last_quo_q;
    last_rem_d   = last_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_c) begin
          wait_d        = 1'b1;
          count_d       = CW'(STEPS);
          ctl_d.is_rem  = pcpi_insn[13];
          ctl_d.neg_quo = 1'b0;
          ctl_d.neg_rem = 1'b0;
          if (div0_c) begin
            quo_d = '1;
            rem_d = {1'b0, pcpi_rs1};
          end else if (ovf_c) begin
            quo_d = pcpi_rs1;
            rem_d = '0;
          end else if (hit_c) begin
`ifdef PCPI_DIV_REUSE_EN
            quo_d = last_quo_q;
            rem_d = {1'b0, last_rem_q};
`endif
          end else begin
            quo_d         = mag1_c;
            rem_d         = '0;
            dvs_d         = mag2_c;
            ctl_d.neg_quo = s1_c ^ s2_c;
            ctl_d.neg_rem = s1_c;
          end
`ifdef PCPI_DIV_REUSE_EN
          // Key is captured now; results become valid only on completion.
          last_valid_d = 1'b0;
          last_uns_d   = pcpi_insn[12];
          last_rs1_d   = pcpi_rs1;
          last_rs2_d   = pcpi_rs2;
`endif
        end
      end
      CALC: begin
        if (!pcpi_valid) begin
          wait_d = 1'b0;
        end else begin
          quo_d   = quo_chain[RADIX_LOG2];
          rem_d   = rem_chain[RADIX_LOG2];
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        rd_d    = ctl_q.is_rem ? r_fin_c : q_fin_c;
        ready_d = 1'b1;
        wr_d    = 1'b1;
        wait_d  = 1'b0;
`ifdef PCPI_DIV_REUSE_EN
        last_valid_d = 1'b1;
        last_quo_d   = q_fin_c;
        last_rem_d   = r_fin_c;
`endif
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      ctl_q   <= '0;
      wait_q  <= 1'b0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
`ifdef PCPI_DIV_REUSE_EN
      last_valid_q <= 1'b0;
      last_uns_q   <= 1'b0;
      last_rs1_q   <= '0;
      last_rs2_q   <= '0;
      last_quo_q   <= '0;
      last_rem_q   <= '0;
`endif
    end else begin
      count_q <= count_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      ctl_q   <= ctl_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
`ifdef PCPI_DIV_REUSE_EN
      last_valid_q <= last_valid_d;
      last_uns_q   <= last_uns_d;
      last_rs1_q   <= last_rs1_d;
      last_rs2_q   <= last_rs2_d;
      last_quo_q   <= last_quo_d;
      last_rem_q   <= last_rem_d;
`endif
    end
  end

  assign pcpi_wait  = wait_q;
  assign pcpi_ready = ready_q;
  assign pcpi_wr    = wr_q;
  assign pcpi_rd    = rd_q;

endmodule

// File: doc/pcpi_div_param.md
Name: pcpi_div_param

Overview:
- Parametrised successor to the single-bit-per-cycle PCPI divider.
- Executes RV M-extension DIV/DIVU/REM/REMU over a configurable data width XLEN.
- Retires RADIX_LOG2 quotient bits per clock.
- Sits on the core's PCPI co-processor port alongside the multiplier.
- Adds a short-latency path for divide-by-zero and signed overflow, and aborts when pcpi_valid is withdrawn.

Parameters:
XLEN, 32, operand/result width; must be a multiple of RADIX_LOG2.
RADIX_LOG2, 1, quotient bits per CALC cycle; legal values 1, 2, 4.

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
pcpi_valid  input  1  instruction offered by core
pcpi_insn  input  32  instruction word
pcpi_rs1  input  XLEN  dividend
pcpi_rs2  input  XLEN  divisor
pcpi_wr  output  1  result write-back strobe, high with pcpi_ready
pcpi_rd  output  XLEN  result
pcpi_wait  output  1  busy indication to core
pcpi_ready  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - Asynchronous; resetn=0 forces the state to IDLE immediately.
  - pcpi_wr=0, pcpi_ready=0, pcpi_wait=0, pcpi_rd=0.
  - Counter and datapath registers are cleared.
  - Reset mid-operation discards the operation; no ready is issued.
- Decode (match):
  - insn[6:0]=0110011, insn[31:25]=0000001 and insn[14]=1.
  - funct3 100=DIV, 101=DIVU, 110=REM, 111=REMU.
  - Non-matching instructions are ignored; all outputs stay 0.
- States: IDLE, CALC, DONE, HOLD.
  - IDLE: when pcpi_valid & match at edge E0 → latch the operation and set pcpi_wait=1 (registered).
    - Signed ops: latch |rs1|, |rs2| and the sign flags.
    - Special case detected at E0 → DONE. Otherwise → CALC with count = XLEN/RADIX_LOG2.
  - CALC: each edge performs RADIX_LOG2 chained restoring steps (shift, trial subtract, set quotient bit) and decrements the count.
    - count reaches 0 → DONE.
    - pcpi_valid=0 at any CALC edge → abort to IDLE; wait cleared, no ready.
  - DONE: one edge registers the sign-corrected result into pcpi_rd, sets pcpi_ready=1 and pcpi_wr=1 for exactly one cycle, and clears pcpi_wait. Next state HOLD.
  - HOLD: ready/wr return to 0; pcpi_rd holds its value.
    - Stays until pcpi_valid is sampled 0, then → IDLE.
    - Guarantees no double execution of the same instruction.
- Latency (edges from E0 to pcpi_ready high):
  - Normal: XLEN/RADIX_LOG2 + 1 (33 at defaults; 17 with RADIX_LOG2=2).
  - Special cases: 1.
- Results:
  - Quotient negated iff signed and the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
  - Divisor 0: quotient = all ones, remainder = rs1 (all ops).
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones): quotient = rs1, remainder = 0.
  - Most-negative dividend with any other divisor is handled correctly via XLEN-bit magnitude.
- Width: internal remainder accumulator XLEN+1 bits; trial subtract XLEN+1 bits.

Optional Feature:
- Macro: PCPI_DIV_REUSE_EN.
- Defined:
  - Keeps the last completed rs1, rs2, signedness (funct3[0]), quotient and remainder, plus a valid flag.
  - A new op matching rs1, rs2 and signedness skips CALC: latency 1, result taken from the stored value (DIV followed by REM costs one extra edge).
  - Valid flag cleared by reset and by abort.
- Undefined: no storage, every non-special op takes the full latency.

Decomposition:
- Package pcpi_div_pkg:
  - OPCODE_OP=7'b0110011 and FUNCT7_MULDIV=7'b0000001.
  - funct3 constants F3_DIV/F3_DIVU/F3_REM/F3_REMU.
  - State enum div_state_t {IDLE, CALC, DONE, HOLD}.
- Sub-module pcpi_div_step: one combinational restoring step, parametrised by XLEN; instantiated RADIX_LOG2 times in a chain inside CALC.

Test Plan:
- XLEN=32, RADIX_LOG2=2, DIV -20/3 → pcpi_rd=-6 (0xFFFFFFFA), ready 17 edges after E0, wr high only that cycle; REM -20/3 → -2; DIV 20/-3 → -6; REM 20/-3 → 2.
- DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF; REMU same → 1; DIVU 20/0 → 0xFFFFFFFF, REM 20/0 → 20, both with latency 1.
- DIV 0x80000000/-1 → 0x80000000, REM same → 0, latency 1; DIV 0x80000000/3 → 0xD5555556.
- Abort: DIV 100/7 accepted, pcpi_valid dropped after 5 CALC edges → no ready, wait falls. Re-issue → 14 with full latency.
- Hold: pcpi_valid held high 3 cycles after ready → no second ready. Non-M insn (insn[31:25]=0) → outputs stay 0.
- RADIX_LOG2=1 build: DIVU 20/3 → 6 with latency 33. With PCPI_DIV_REUSE_EN, REMU 20/3 issued next → 2 with latency 1.
